// File: rtl/myo_spi_slave.sv
// Motor-board SPI responder for the myocontrol frame (16-bit words, CPOL=0, CPHA=1).
// Define MYO_SLAVE_WATCHDOG_EN to add the frame watchdog that forces pwm_ref to 0.
module myo_spi_slave #(
    parameter logic [15:0] HEADER          = 16'h8000,
    parameter int          FRAME_WORDS     = 8,
    parameter int unsigned WATCHDOG_CYCLES = 5_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sck,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    input  logic signed [31:0] position,
    input  logic        [15:0] velocity,
    input  logic        [15:0] current,
    input  logic        [15:0] displacement,
    input  logic        [15:0] sensor1,
    input  logic        [15:0] sensor2,
    output logic signed [15:0] pwm_ref,
    output logic               pwm_valid,
    output logic               frame_error,
    output logic        [15:0] frame_count,
    output logic               timeout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic [3:0] LAST_WORD = 4'(FRAME_WORDS);

    if (FRAME_WORDS != 8 || WATCHDOG_CYCLES == 0) begin : g_bad_cfg
        $error("myo_spi_slave: FRAME_WORDS must be 8 and WATCHDOG_CYCLES nonzero");
    end

    logic [2:0]   sck_q;
    logic [2:0]   ss_q;
    logic [1:0]   mosi_q;
    logic [1:0]   state;
    logic [3:0]   bit_cnt;
    logic [3:0]   word_cnt;
    logic         ovf;
    logic         hdr_ok;
    logic [14:0]  rx_shift;
    logic [15:0]  pwm_hold;
    logic [127:0] snapshot;

    logic        sck_rise;
    logic        sck_fall;
    logic        ss_fall;
    logic        ss_rise;
    logic [15:0] word;
    logic [6:0]  bit_idx;
    logic        accept;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ss_fall  = ~ss_q[1] & ss_q[2];
    assign ss_rise  = ss_q[1] & ~ss_q[2];
    assign word     = {rx_shift, mosi_q[1]};
    // Word 0 sits in the top 16 bits, so the bit index is the inverted position.
    assign bit_idx  = ~{word_cnt[2:0], bit_cnt};
    assign accept   = (state == CHECK) && (word_cnt == LAST_WORD) && !ovf &&
                      (bit_cnt == 4'd0) && hdr_ok;

`ifdef MYO_SLAVE_WATCHDOG_EN
    localparam logic [31:0] WD_MAX = 32'(WATCHDOG_CYCLES);
    localparam logic [31:0] WD_PRE = WD_MAX - 32'd1;
    logic [31:0] wd_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            sck_q       <= 3'b000;
            ss_q        <= 3'b111;
            mosi_q      <= 2'b00;
            state       <= IDLE;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            ovf         <= 1'b0;
            hdr_ok      <= 1'b0;
            rx_shift    <= '0;
            pwm_hold    <= '0;
            pwm_ref     <= '0;
            pwm_valid   <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
`ifdef MYO_SLAVE_WATCHDOG_EN
            wd_cnt      <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            sck_q       <= {sck_q[1:0], sck};
            ss_q        <= {ss_q[1:0], ss_n};
            mosi_q      <= {mosi_q[0], mosi};
            pwm_valid   <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        snapshot <= {HEADER, position, velocity, current,
                                     displacement, sensor1, sensor2};
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        ovf      <= 1'b0;
                        hdr_ok   <= 1'b0;
                        miso_oe  <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A release of ss_n outranks any sck edge seen in the same cycle.
                    if (ss_rise) begin
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                        state   <= CHECK;
                    end else if (sck_rise) begin
                        miso <= word_cnt[3] ? 1'b0 : snapshot[bit_idx];
                    end else if (sck_fall) begin
                        rx_shift <= word[14:0];
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            if (word_cnt == 4'd0) hdr_ok <= (word == HEADER);
                            if (word_cnt == 4'd1) pwm_hold <= word;
                            if (word_cnt == LAST_WORD) ovf <= 1'b1;
                            else word_cnt <= word_cnt + 4'd1;
                        end
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (accept) begin
                        pwm_ref     <= pwm_hold;
                        pwm_valid   <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef MYO_SLAVE_WATCHDOG_EN
            if (accept) begin
                wd_cnt  <= '0;
                timeout <= 1'b0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 32'd1;
                if (wd_cnt == WD_PRE) begin
                    timeout   <= 1'b1;
                    pwm_ref   <= '0;
                    pwm_valid <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: doc/myo_spi_slave.md
Name: myo_spi_slave

Overview:
- Motor-board-side SPI responder for the myocontrol frame issued by the FPGA-side SPI master (16-bit words, MSB first, CPOL=0, CPHA=1).
- Receives the header and pwmRef command from the master.
- Returns a telemetry snapshot: position, velocity, current, displacement, sensor1, sensor2.
- Sits between the board's SPI pins and its local motor driver / sensor logic. It provides the bench counterpart for end-to-end verification of the master side.

Parameters:
- HEADER, 16'h8000, required master word 0; the slave returns the same value in word 0.
- FRAME_WORDS, 8, words per frame (fixed frame layout below; must be 8).
- WATCHDOG_CYCLES, 5_000_000, clock cycles without a valid frame before timeout (optional feature only).

Ports:
- clock  in  1  system clock; must be ≥ 8× sck frequency.
- reset  in  1  synchronous, active-low reset.
- sck  in  1  SPI clock from master, asynchronous.
- ss_n  in  1  slave select, active low, asynchronous.
- mosi  in  1  master data, asynchronous.
- miso  out  1  slave data.
- miso_oe  out  1  miso output enable; high while ss_n is synchronised low.
- position  in  32  signed telemetry input.
- velocity, current, displacement, sensor1, sensor2  in  16 each  telemetry inputs.
- pwm_ref  out  16  signed, last accepted pwmRef.
- pwm_valid  out  1  one-cycle pulse when pwm_ref updates.
- frame_error  out  1  one-cycle pulse on a rejected frame.
- frame_count  out  16  count of accepted frames; wraps 16'hFFFF→0.
- timeout  out  1  watchdog flag (held 0 when the feature is compiled out).

Behaviour:
- Reset (reset==0 at posedge clock):
  - pwm_ref=0, pwm_valid=0, frame_error=0, frame_count=0, timeout=0, miso=0, miso_oe=0.
  - Sync flops load idle values: sck=0, ss_n=1, mosi=0.
  - State returns to IDLE.
  - Reset asserted mid-frame discards the frame; no pulses are generated.
- Synchronisation and edge detection:
  - sck, ss_n and mosi each pass through a 2-flop synchroniser.
  - Edges are detected on the synchronised versions; edge-detect latency is 3 clocks.
- Frame layout, word n (master sends / slave returns):
  - 0: HEADER / HEADER
  - 1: pwmRef / position[31:16]
  - 2: 0 / position[15:0]
  - 3: 0 / velocity
  - 4: 0 / current
  - 5: 0 / displacement
  - 6: 0 / sensor1
  - 7: 0 / sensor2
- Snapshot: on the synchronised ss_n falling edge, all telemetry inputs are latched into a 128-bit snapshot register. Inputs changing mid-frame do not affect the frame.
- State machine:
  - IDLE → SHIFT on ss_n fall.
    - Clear bit_cnt (4 bits) and word_cnt (3 bits plus overflow bit).
    - Set miso_oe=1.
  - SHIFT, sck rising edge: miso ← snapshot bit (word_cnt, 15−bit_cnt).
  - SHIFT, sck falling edge: shift mosi into rx_shift and increment bit_cnt.
    - When bit_cnt wraps 15→0, the word is complete.
    - Word 0 is compared to HEADER and the result stored in hdr_ok.
    - Word 1 is stored in pwm_hold.
    - word_cnt increments and saturates at 8 (overflow flag set).
  - SHIFT → CHECK on ss_n rise. miso_oe=0 and miso=0 in the same cycle.
  - CHECK, one cycle, then IDLE:
    - Accept when exactly 8 complete words, bit_cnt==0 and hdr_ok=1. Then pwm_ref ← pwm_hold, pwm_valid pulse, frame_count+1.
    - Otherwise, reject: frame_error pulse, pwm_ref unchanged.
- Boundary cases (all reject):
  - Partial word (ss_n rise with bit_cnt≠0).
  - Fewer than 8 words.
  - More than 8 words (overflow flag).
  - Header mismatch.
- sck edges while ss_n is high are ignored.
- Simultaneous sck edge and ss_n rise in the same synchronised cycle: the ss_n rise wins and the sck edge is ignored.

Optional Feature:
- Macro: MYO_SLAVE_WATCHDOG_EN.
- Defined:
  - A 32-bit counter increments every clock and clears on each accepted frame.
  - On reaching WATCHDOG_CYCLES: timeout=1, pwm_ref forced to 0, pwm_valid pulses once, counter holds.
  - The next accepted frame clears timeout and loads pwm_ref normally.
- Undefined: timeout tied to 0; pwm_ref holds its last value indefinitely.

Test Plan:
- Valid frame: header 16'h8000, pwmRef 16'h0123; position=32'h89ABCDEF, velocity=16'h0010, current=16'h0020, displacement=16'hFFF0, sensor1=1, sensor2=2.
  - Response: miso words 8000,89AB,CDEF,0010,0020,FFF0,0001,0002; then pwm_ref=16'h0123, one pwm_valid pulse, frame_count=1.
- Header 16'h4000 with pwmRef 16'h0055 → frame_error pulse, pwm_ref unchanged, frame_count unchanged.
- ss_n released after 7 words + 5 bits → frame_error; a following valid frame with pwmRef 16'hFF00 is accepted, pwm_ref=16'hFF00.
- Telemetry position changed from 1 to 2 mid-frame → returned words 1–2 read 0000,0001.
- reset=0 asserted during word 3 → all outputs return to reset values, no pulses; the next valid frame is accepted normally.
- Watchdog (WATCHDOG_CYCLES=1000, macro defined): valid frame with pwmRef 16'h0100, then idle → timeout=1 and pwm_ref=0 at cycle 1000 after acceptance; the next valid frame clears timeout.
